// File: rtl/music_pkg.sv
// Shared definitions for the melody sequencer: note codes, ROM word layout and FSM state encoding.
package music_pkg;

    localparam int CODE_W = 4;
    localparam int DUR_W  = 3;
    localparam int IDX_W  = 5;
    localparam int ROM_W  = CODE_W + DUR_W;

    // ROM word layout {code, dur}
    localparam int CODE_HI = ROM_W - 1;
    localparam int CODE_LO = DUR_W;
    localparam int DUR_HI  = DUR_W - 1;
    localparam int DUR_LO  = 0;

    localparam logic [CODE_W-1:0] NOTE_REST = 4'd0;
    localparam logic [CODE_W-1:0] NOTE_C4   = 4'd1;
    localparam logic [CODE_W-1:0] NOTE_D4   = 4'd2;
    localparam logic [CODE_W-1:0] NOTE_E4   = 4'd3;
    localparam logic [CODE_W-1:0] NOTE_F4   = 4'd4;
    localparam logic [CODE_W-1:0] NOTE_G4   = 4'd5;
    localparam logic [CODE_W-1:0] NOTE_A4   = 4'd6;
    localparam logic [CODE_W-1:0] NOTE_AS4  = 4'd7;
    localparam logic [CODE_W-1:0] NOTE_C5   = 4'd8;

    typedef logic [ROM_W-1:0] rom_word_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SOUND  = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_t;

    function automatic rom_word_t rom_entry(input logic [CODE_W-1:0] code,
                                            input logic [DUR_W-1:0] dur);
        return {code, dur};
    endfunction

    function automatic logic [CODE_W-1:0] word_code(input rom_word_t w);
        return w[CODE_HI:CODE_LO];
    endfunction

    function automatic logic [DUR_W-1:0] word_dur(input rom_word_t w);
        return w[DUR_HI:DUR_LO];
    endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control and note-output bundle between the sequencer and its controller / tone stage.
interface melody_sequencer_if;
    import music_pkg::*;

    logic               play;
    logic               stop;
    logic [CODE_W-1:0]  note_code;
    logic               note_valid;
    logic [IDX_W-1:0]   note_idx;
    logic               busy;
    logic               done;

    modport master (
        output play,
        output stop,
        input  note_code,
        input  note_valid,
        input  note_idx,
        input  busy,
        input  done
    );

    modport slave (
        input  play,
        input  stop,
        output note_code,
        output note_valid,
        output note_idx,
        output busy,
        output done
    );

endinterface

// File: rtl/beat_tick_gen.sv
// Beat tick generator: down-counter that pulses tick once every TICK_DIV cycles after clr drops.
module beat_tick_gen #(
    parameter int TICK_DIV = 750000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (clr || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

    // Terminal count; the reload on tick keeps consecutive beats exactly TICK_DIV apart
    assign tick = (cnt == '0) && !clr;

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: walks the melody ROM and presents one note code per entry, with timed gaps.
//
// state  | meaning
// IDLE   | silent, waiting for play
// LOAD   | one silent cycle, latch ROM word for note_idx
// SOUND  | note_code driven for (dur+1) beat ticks
// GAP    | silent articulation for GAP_TICKS beat ticks
// FINISH | one cycle after the last entry of a non-looping song
module melody_sequencer
    import music_pkg::*;
#(
    parameter int TICK_DIV  = 750000,
    parameter int SONG_LEN  = 25,
    parameter int GAP_TICKS = 1,
    parameter int LOOP      = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    melody_sequencer_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);
    localparam logic [DUR_W-1:0] GAP_LAST = DUR_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam bit               HAS_GAP  = (GAP_TICKS > 0);
    localparam bit               DO_LOOP  = (LOOP != 0);

    seq_state_t        state;
    seq_state_t        adv_state;
    rom_word_t         rom_word;
    rom_word_t         rom_rd;
    logic [DUR_W-1:0]  tick_cnt;
    logic [IDX_W-1:0]  adv_idx;
    logic [CODE_W-1:0] note_code_q;
    logic              note_valid_q;
    logic [IDX_W-1:0]  note_idx_q;
    logic              busy_q;
    logic              done_q;
    logic              tick;
    logic              tick_clr;

    function automatic rom_word_t rom_lookup(input logic [IDX_W-1:0] idx);
        rom_word_t w;
        case (idx)
            5'd0:    w = rom_entry(NOTE_C4,  3'd0);
            5'd1:    w = rom_entry(NOTE_C4,  3'd0);
            5'd2:    w = rom_entry(NOTE_D4,  3'd0);
            5'd3:    w = rom_entry(NOTE_C4,  3'd0);
            5'd4:    w = rom_entry(NOTE_F4,  3'd0);
            5'd5:    w = rom_entry(NOTE_E4,  3'd1);
            5'd6:    w = rom_entry(NOTE_C4,  3'd0);
            5'd7:    w = rom_entry(NOTE_C4,  3'd0);
            5'd8:    w = rom_entry(NOTE_D4,  3'd0);
            5'd9:    w = rom_entry(NOTE_C4,  3'd0);
            5'd10:   w = rom_entry(NOTE_G4,  3'd0);
            5'd11:   w = rom_entry(NOTE_F4,  3'd1);
            5'd12:   w = rom_entry(NOTE_C4,  3'd0);
            5'd13:   w = rom_entry(NOTE_C4,  3'd0);
            5'd14:   w = rom_entry(NOTE_C5,  3'd0);
            5'd15:   w = rom_entry(NOTE_A4,  3'd0);
            5'd16:   w = rom_entry(NOTE_F4,  3'd0);
            5'd17:   w = rom_entry(NOTE_E4,  3'd0);
            5'd18:   w = rom_entry(NOTE_D4,  3'd1);
            5'd19:   w = rom_entry(NOTE_AS4, 3'd0);
            5'd20:   w = rom_entry(NOTE_AS4, 3'd0);
            5'd21:   w = rom_entry(NOTE_A4,  3'd0);
            5'd22:   w = rom_entry(NOTE_F4,  3'd0);
            5'd23:   w = rom_entry(NOTE_G4,  3'd0);
            5'd24:   w = rom_entry(NOTE_F4,  3'd3);
            default: w = rom_entry(NOTE_REST, 3'd0);
        endcase
        return w;
    endfunction

    // Beat timer only runs while a note or gap is being timed
    assign tick_clr = (state != ST_SOUND) && (state != ST_GAP);

    beat_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_beat_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_comb begin
        rom_rd    = rom_lookup(note_idx_q);
        adv_idx   = note_idx_q;
        adv_state = ST_FINISH;
        if (note_idx_q < LAST_IDX) begin
            adv_idx   = note_idx_q + IDX_W'(1);
            adv_state = ST_LOAD;
        end else if (DO_LOOP) begin
            adv_idx   = '0;
            adv_state = ST_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rom_word     <= '0;
            tick_cnt     <= '0;
            note_code_q  <= NOTE_REST;
            note_valid_q <= 1'b0;
            note_idx_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != ST_IDLE && bus.stop) begin
                state        <= ST_IDLE;
                note_code_q  <= NOTE_REST;
                note_valid_q <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.play && !bus.stop) begin
                            state      <= ST_LOAD;
                            note_idx_q <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        rom_word     <= rom_rd;
                        note_code_q  <= word_code(rom_rd);
                        note_valid_q <= 1'b1;
                        tick_cnt     <= '0;
                        state        <= ST_SOUND;
                    end
                    ST_SOUND: begin
                        if (tick) begin
                            if (tick_cnt == word_dur(rom_word)) begin
                                note_code_q  <= NOTE_REST;
                                note_valid_q <= 1'b0;
                                tick_cnt     <= '0;
                                if (HAS_GAP) begin
                                    state <= ST_GAP;
                                end else begin
                                    state      <= adv_state;
                                    note_idx_q <= adv_idx;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + DUR_W'(1);
                            end
                        end
                    end
                    ST_GAP: begin
                        if (tick) begin
                            if (tick_cnt == GAP_LAST) begin
                                tick_cnt   <= '0;
                                state      <= adv_state;
                                note_idx_q <= adv_idx;
                            end else begin
                                tick_cnt <= tick_cnt + DUR_W'(1);
                            end
                        end
                    end
                    ST_FINISH: begin
                        // done is issued on the FINISH exit so a stop sampled in FINISH cancels it
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                    default: begin
                        state        <= ST_IDLE;
                        note_code_q  <= NOTE_REST;
                        note_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.note_code  = note_code_q;
    assign bus.note_valid = note_valid_q;
    assign bus.note_idx   = note_idx_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: scoreboard of expected notes plus per-scenario timing checks.
module tb_melody_sequencer;

    typedef struct {
        int idx;
        int code;
        int len;
    } note_t;

    localparam int TD = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    melody_sequencer_if bus_a();
    melody_sequencer_if bus_b();

    melody_sequencer #(.TICK_DIV(TD), .SONG_LEN(25), .GAP_TICKS(1), .LOOP(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    melody_sequencer #(.TICK_DIV(TD), .SONG_LEN(3), .GAP_TICKS(0), .LOOP(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int rom_codes [25] = '{1,1,2,1,4,3, 1,1,2,1,5,4, 1,1,8,6,4,3,2, 7,7,6,4,5,4};
    int rom_durs  [25] = '{0,0,0,0,0,1, 0,0,0,0,0,1, 0,0,0,0,0,0,1, 0,0,0,0,0,3};

    note_t sb_q[$];
    bit    mon_en = 0;
    bit    prev_v = 0;
    bit    have_cur = 0;
    int    run_len = 0;
    note_t cur;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic note_t exp_note(input int i);
        note_t n;
        n.idx  = i;
        n.code = rom_codes[i];
        n.len  = (rom_durs[i] + 1) * TD;
        return n;
    endfunction

    task automatic push_notes(input int first, input int last);
        for (int i = first; i <= last; i++) sb_q.push_back(exp_note(i));
    endtask

    // Scoreboard consumer for dut_a: one pop per note start, length check per completed note
    always @(negedge clk) begin
        if (!mon_en) begin
            prev_v = 0;
        end else begin
            if (bus_a.note_valid && !prev_v) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    have_cur = 0;
                    $display("FAIL sb_extra_note: got idx %0d code %0d, expected no note", bus_a.note_idx, bus_a.note_code);
                end else begin
                    cur = sb_q.pop_front();
                    have_cur = 1;
                    if (bus_a.note_code !== 4'(cur.code) || bus_a.note_idx !== 5'(cur.idx)) begin
                        errors++;
                        $display("FAIL sb_note: got idx %0d code %0d, expected idx %0d code %0d",
                                 bus_a.note_idx, bus_a.note_code, cur.idx, cur.code);
                    end
                end
                run_len = 1;
            end else if (bus_a.note_valid) begin
                run_len++;
            end else if (prev_v && bus_a.busy && have_cur) begin
                checks++;
                if (run_len != cur.len) begin
                    errors++;
                    $display("FAIL sb_note_len: idx %0d lasted %0d cycles, expected %0d", cur.idx, run_len, cur.len);
                end
            end
            prev_v = bus_a.note_valid;
        end
    end

    task automatic test_reset();
        rst_n = 0;
        repeat (3) step();
        checks++;
        if ({bus_a.note_code, bus_a.note_valid, bus_a.note_idx, bus_a.busy, bus_a.done} !== 12'd0) begin
            errors++;
            $display("FAIL reset_a: outputs %b expected all zero",
                     {bus_a.note_code, bus_a.note_valid, bus_a.note_idx, bus_a.busy, bus_a.done});
        end
        checks++;
        if ({bus_b.note_code, bus_b.note_valid, bus_b.note_idx, bus_b.busy, bus_b.done} !== 12'd0) begin
            errors++;
            $display("FAIL reset_b: outputs %b expected all zero",
                     {bus_b.note_code, bus_b.note_valid, bus_b.note_idx, bus_b.busy, bus_b.done});
        end
        rst_n = 1;
        repeat (2) step();
        checks++;
        if (bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy %b expected 0", bus_a.busy);
        end
    endtask

    task automatic test_play_latency();
        sb_q.delete();
        push_notes(0, 1);
        mon_en = 1;
        bus_a.play = 1;
        step();
        bus_a.play = 0;
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.note_valid !== 1'b0 || bus_a.note_code !== 4'd0) begin
            errors++;
            $display("FAIL lat_load: busy %b valid %b code %0d expected 1 0 0", bus_a.busy, bus_a.note_valid, bus_a.note_code);
        end
        for (int e = 2; e <= 5; e++) begin
            step();
            checks++;
            if (bus_a.note_valid !== 1'b1 || bus_a.note_code !== 4'd1 || bus_a.note_idx !== 5'd0) begin
                errors++;
                $display("FAIL lat_sound@%0d: valid %b code %0d idx %0d expected 1 1 0",
                         e, bus_a.note_valid, bus_a.note_code, bus_a.note_idx);
            end
        end
        for (int e = 6; e <= 9; e++) begin
            step();
            checks++;
            if (bus_a.note_valid !== 1'b0 || bus_a.note_code !== 4'd0 || bus_a.busy !== 1'b1) begin
                errors++;
                $display("FAIL lat_gap@%0d: valid %b code %0d busy %b expected 0 0 1",
                         e, bus_a.note_valid, bus_a.note_code, bus_a.busy);
            end
        end
        step();
        checks++;
        if (bus_a.note_valid !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.note_idx !== 5'd1) begin
            errors++;
            $display("FAIL lat_load2: valid %b busy %b idx %0d expected 0 1 1", bus_a.note_valid, bus_a.busy, bus_a.note_idx);
        end
        step();
        checks++;
        if (bus_a.note_valid !== 1'b1 || bus_a.note_code !== 4'd1 || bus_a.note_idx !== 5'd1) begin
            errors++;
            $display("FAIL lat_note1: valid %b code %0d idx %0d expected 1 1 1", bus_a.note_valid, bus_a.note_code, bus_a.note_idx);
        end
        bus_a.stop = 1;
        step();
        bus_a.stop = 0;
        checks++;
        if (bus_a.busy !== 1'b0 || bus_a.note_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_stop: busy %b valid %b expected 0 0", bus_a.busy, bus_a.note_valid);
        end
        mon_en = 0;
    endtask

    task automatic test_full_song();
        int t = 0, t_first = -1, t_done = -1, done_cnt = 0, done_idx = -1;
        sb_q.delete();
        push_notes(0, 24);
        step();
        mon_en = 1;
        bus_a.play = 1;
        step();
        bus_a.play = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            t++;
            if (bus_a.note_valid && t_first < 0) t_first = t;
            if (bus_a.done) begin
                done_cnt++;
                if (t_done < 0) begin
                    t_done = t;
                    done_idx = bus_a.note_idx;
                end
            end
            if (t_done >= 0 && t > t_done + 4) break;
        end
        checks++;
        if (t_done < 0) begin
            errors++;
            $display("FAIL song_done_timeout: done never seen, expected within 600 cycles");
        end
        checks++;
        if (t_done - t_first != 249) begin
            errors++;
            $display("FAIL song_length: first valid to done %0d cycles, expected 249", t_done - t_first);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL song_done_width: done high %0d cycles, expected 1", done_cnt);
        end
        checks++;
        if (done_idx != 24) begin
            errors++;
            $display("FAIL song_done_idx: note_idx %0d at done, expected 24", done_idx);
        end
        checks++;
        if (sb_q.size() != 0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL song_end: %0d notes not played, busy %b, expected 0 and 0", sb_q.size(), bus_a.busy);
        end
        mon_en = 0;
    endtask

    task automatic test_stop();
        bit found = 0, saw_done = 0;
        sb_q.delete();
        push_notes(0, 4);
        mon_en = 1;
        bus_a.play = 1;
        step();
        bus_a.play = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (bus_a.note_valid && bus_a.note_idx == 5'd4) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL stop_wait: idx 4 never sounded within 200 cycles");
        end
        step();
        bus_a.stop = 1;
        step();
        bus_a.stop = 0;
        checks++;
        if (bus_a.note_valid !== 1'b0 || bus_a.note_code !== 4'd0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: valid %b code %0d busy %b expected 0 0 0", bus_a.note_valid, bus_a.note_code, bus_a.busy);
        end
        for (int c = 0; c < 30; c++) begin
            step();
            if (bus_a.done || bus_a.busy) saw_done = 1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL stop_no_done: done or busy seen after stop, expected neither");
        end
        mon_en = 0;
    endtask

    task automatic test_play_stop();
        bit started = 0, found = 0;
        bus_a.play = 1;
        bus_a.stop = 1;
        step();
        bus_a.play = 0;
        bus_a.stop = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus_a.busy) started = 1;
        end
        checks++;
        if (started) begin
            errors++;
            $display("FAIL play_stop_idle: busy seen after play+stop, expected stay idle");
        end
        sb_q.delete();
        push_notes(0, 4);
        mon_en = 1;
        bus_a.play = 1;
        step();
        bus_a.play = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            step();
            if (bus_a.note_valid && bus_a.note_idx == 5'd3) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL busy_play_wait: idx 3 never sounded within 200 cycles");
        end
        step();
        bus_a.play = 1;
        step();
        bus_a.play = 0;
        repeat (6) step();
        checks++;
        if (bus_a.note_valid !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.note_idx !== 5'd4) begin
            errors++;
            $display("FAIL busy_play_load: valid %b busy %b idx %0d expected 0 1 4", bus_a.note_valid, bus_a.busy, bus_a.note_idx);
        end
        step();
        checks++;
        if (bus_a.note_valid !== 1'b1 || bus_a.note_idx !== 5'd4 || bus_a.note_code !== 4'd4) begin
            errors++;
            $display("FAIL busy_play_next: valid %b idx %0d code %0d expected 1 4 4",
                     bus_a.note_valid, bus_a.note_idx, bus_a.note_code);
        end
        bus_a.stop = 1;
        step();
        bus_a.stop = 0;
        mon_en = 0;
    endtask

    task automatic test_reset_mid_song();
        bit found = 0, saw_bad = 0;
        sb_q.delete();
        push_notes(0, 7);
        mon_en = 1;
        bus_a.play = 1;
        step();
        bus_a.play = 0;
        for (int c = 0; c < 300 && !found; c++) begin
            step();
            if (bus_a.note_valid && bus_a.note_idx == 5'd7) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_mid_wait: idx 7 never sounded within 300 cycles");
        end
        step();
        rst_n = 0;
        repeat (3) begin
            step();
            if (bus_a.done) saw_bad = 1;
        end
        rst_n = 1;
        step();
        checks++;
        if ({bus_a.note_code, bus_a.note_valid, bus_a.note_idx, bus_a.busy, bus_a.done} !== 12'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: %b expected all zero",
                     {bus_a.note_code, bus_a.note_valid, bus_a.note_idx, bus_a.busy, bus_a.done});
        end
        repeat (10) begin
            step();
            if (bus_a.done || bus_a.busy || bus_a.note_valid) saw_bad = 1;
        end
        checks++;
        if (saw_bad || sb_q.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_idle: activity %b, %0d notes left, expected none", saw_bad, sb_q.size());
        end
        mon_en = 0;
    endtask

    task automatic test_loop();
        note_t q[$];
        note_t n;
        int popped = 0, hi_len = 0, lo_len = 0;
        bit pv = 0, seen_fall = 0, saw_done = 0;
        for (int k = 0; k < 7; k++) begin
            n.idx  = k % 3;
            n.code = rom_codes[k % 3];
            n.len  = TD;
            q.push_back(n);
        end
        bus_b.play = 1;
        step();
        bus_b.play = 0;
        for (int c = 0; c < 150 && popped < 7; c++) begin
            step();
            if (bus_b.done) saw_done = 1;
            if (bus_b.note_valid && !pv) begin
                n = q.pop_front();
                popped++;
                checks++;
                if (bus_b.note_idx !== 5'(n.idx) || bus_b.note_code !== 4'(n.code)) begin
                    errors++;
                    $display("FAIL loop_note%0d: idx %0d code %0d expected idx %0d code %0d",
                             popped, bus_b.note_idx, bus_b.note_code, n.idx, n.code);
                end
                if (seen_fall) begin
                    checks++;
                    if (lo_len != 1) begin
                        errors++;
                        $display("FAIL loop_load_gap: silent %0d cycles between notes, expected 1", lo_len);
                    end
                end
                hi_len = 1;
            end else if (bus_b.note_valid) begin
                hi_len++;
            end else if (pv) begin
                seen_fall = 1;
                lo_len = 1;
                checks++;
                if (hi_len != TD) begin
                    errors++;
                    $display("FAIL loop_note_len: note lasted %0d cycles, expected %0d", hi_len, TD);
                end
            end else begin
                lo_len++;
            end
            pv = bus_b.note_valid;
        end
        checks++;
        if (popped != 7 || saw_done) begin
            errors++;
            $display("FAIL loop_summary: %0d notes seen (expected 7), done seen %b (expected 0)", popped, saw_done);
        end
        bus_b.stop = 1;
        step();
        bus_b.stop = 0;
    endtask

    initial begin
        rst_n = 0;
        bus_a.play = 0;
        bus_a.stop = 0;
        bus_b.play = 0;
        bus_b.stop = 0;
        test_reset();
        test_play_latency();
        test_full_song();
        test_stop();
        test_play_stop();
        test_reset_mid_song();
        test_loop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
